// File: rtl/signed_seq_divider.sv
// ============================================================================
// signed_seq_divider : restoring signed divider, 2W-bit / W-bit, fixed latency
// Revision 1.0
// ============================================================================
`default_nettype none

module signed_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic                 dbz
);

  localparam int CW = $clog2(2*WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_DIV    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [2*WIDTH-1:0] LIM_POS  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] LIM_NEG  = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   Q_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]   Q_MIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]      CNT_LAST = CW'(2*WIDTH-1);

  logic [1:0]         r_state;
  // r_dvd holds the raw dividend, then its magnitude, and shifts quotient bits in
  logic [2*WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH:0]     r_prem;
  logic [CW-1:0]      r_cnt;
  logic               r_sign_dvd;
  logic               r_sign_dvs;
  logic               r_dbz_flag;

  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_dvs_ext;
  logic [WIDTH+1:0]   w_diff;
  logic               w_ge;
  logic               w_neg;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_qmag;
  logic [WIDTH-1:0]   w_rmag;

  assign w_shift   = {r_prem, r_dvd[2*WIDTH-1]};
  assign w_dvs_ext = {2'b00, r_dvs};
  assign w_diff    = w_shift - w_dvs_ext;
  assign w_ge      = (w_shift >= w_dvs_ext);
  assign w_neg     = r_sign_dvd ^ r_sign_dvs;
  assign w_ovf     = (r_dvd > (w_neg ? LIM_NEG : LIM_POS));
  assign w_qmag    = r_dvd[WIDTH-1:0];
  assign w_rmag    = r_prem[WIDTH-1:0];

  // DIV and FINISH are the only states with the top state bit set
  assign busy = r_state[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_prem     <= '0;
      r_cnt      <= '0;
      r_sign_dvd <= 1'b0;
      r_sign_dvs <= 1'b0;
      r_dbz_flag <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      dbz        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sign_dvd <= r_dvd[2*WIDTH-1];
          r_sign_dvs <= r_dvs[WIDTH-1];
          r_dvd      <= r_dvd[2*WIDTH-1] ? -r_dvd : r_dvd;
          r_dvs      <= r_dvs[WIDTH-1] ? -r_dvs : r_dvs;
          r_prem     <= '0;
          r_cnt      <= CNT_LAST;
          r_dbz_flag <= (r_dvs == '0);
          r_state    <= S_DIV;
        end
        S_DIV: begin
          r_prem <= w_ge ? (WIDTH+1)'(w_diff) : (WIDTH+1)'(w_shift);
          r_dvd  <= {r_dvd[2*WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          done <= 1'b1;
          dbz  <= r_dbz_flag;
          if (r_dbz_flag) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
          end else begin
            ovf       <= w_ovf;
            quotient  <= w_ovf ? (w_neg ? Q_MIN : Q_MAX) : (w_neg ? -w_qmag : w_qmag);
            remainder <= r_sign_dvd ? -w_rmag : w_rmag;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_signed_seq_divider.sv
// ============================================================================
// tb_signed_seq_divider : directed and random checks against an integer model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_signed_seq_divider;

  localparam int W = 4;

  logic           clk;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           ovf;
  logic           dbz;

  int checks   = 0;
  int failures = 0;

  signed_seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: truncating division, saturate when outside signed W range
  task automatic model(input int a, input int b, output logic [W-1:0] q,
                       output logic [W-1:0] r, output logic o, output logic z);
    int qt;
    int rt;
    int hi;
    int lo;
    hi = (1 << (W-1)) - 1;
    lo = -(1 << (W-1));
    if (b == 0) begin
      q = '0; r = '0; o = 1'b0; z = 1'b1;
    end else begin
      qt = a / b;
      rt = a % b;
      z  = 1'b0;
      o  = (qt > hi) || (qt < lo);
      if (qt > hi)      qt = hi;
      else if (qt < lo) qt = lo;
      q = qt[W-1:0];
      r = rt[W-1:0];
    end
  endtask

  task automatic run_op(input int dvd, input int dvs, input bit pulse, input string tag);
    logic [2*W-1:0] dvd_bits;
    logic [W-1:0]   dvs_bits;
    logic [W-1:0]   eq, er, pq, pr;
    logic           eo, ez, po, pz;
    int             done_at, done_cnt, busy_cnt;
    dvd_bits = (2*W)'(dvd);
    dvs_bits = W'(dvs);
    model(int'($signed(dvd_bits)), int'($signed(dvs_bits)), eq, er, eo, ez);
    @(negedge clk);
    pq = quotient; pr = remainder; po = ovf; pz = dbz;
    dividend = dvd_bits;
    divisor  = dvs_bits;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = (2*W)'($urandom);
    divisor  = W'($urandom);
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 2*W+5; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (i == 2*W+1)
        check({tag, " held"}, {22'd0, quotient, remainder, ovf, dbz}, {22'd0, pq, pr, po, pz});
      start = pulse && (i == 2 || i == 6);
    end
    start = 1'b0;
    check({tag, " done_at"},  done_at,  2*W+2);
    check({tag, " done_cnt"}, done_cnt, 1);
    check({tag, " busy_cnt"}, busy_cnt, 2*W+1);
    check({tag, " q"},   {28'd0, quotient},  {28'd0, eq});
    check({tag, " r"},   {28'd0, remainder}, {28'd0, er});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
    check({tag, " dbz"}, {31'd0, dbz}, {31'd0, ez});
  endtask

  initial begin
    int d1, d2;
    logic [W-1:0] q1, r1, q2, r2;

    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("reset outputs", {22'd0, quotient, remainder, ovf, dbz}, 32'd0);
    check("reset busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(35, 6, 1'b0, "35/6");
    run_op(-35, 6, 1'b0, "-35/6");
    run_op(35, -6, 1'b0, "35/-6");
    run_op(-35, -6, 1'b0, "-35/-6");
    run_op(-64, 8, 1'b0, "-64/8");
    run_op(100, 3, 1'b0, "100/3");
    run_op(-128, -8, 1'b0, "-128/-8");
    run_op(-128, 1, 1'b0, "-128/1");
    run_op(77, 0, 1'b1, "77/0 pulsed");
    run_op(-35, 6, 1'b1, "-35/6 pulsed");

    // Reset in the middle of DIV, after an overflowing result left nonzero outputs
    run_op(100, 3, 1'b0, "pre-reset");
    @(negedge clk);
    dividend = 8'd35;
    divisor  = 4'd6;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midreset outputs", {22'd0, quotient, remainder, ovf, dbz}, 32'd0);
    check("midreset busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(35, 6, 1'b0, "post-reset 35/6");

    // start held high: the second operation is accepted in the IDLE cycle of the first done
    @(negedge clk);
    dividend = 8'd35;
    divisor  = 4'd6;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = (2*W)'(-35);
    divisor  = W'(-6);
    d1 = -1; d2 = -1;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int i = 1; i <= 4*W+12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (d1 < 0) begin
          d1 = i; q1 = quotient; r1 = remainder;
        end else if (d2 < 0) begin
          d2 = i; q2 = quotient; r2 = remainder;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b first done",  d1, 2*W+2);
    check("b2b second done", d2, 2*(2*W+2)+1);
    check("b2b q1", {28'd0, q1}, 32'd5);
    check("b2b r1", {28'd0, r1}, 32'd5);
    check("b2b q2", {28'd0, q2}, 32'd5);
    check("b2b r2", {28'd0, r2}, 32'hB);

    for (int n = 0; n < 24; n++) begin
      int rd, rv;
      rd = int'($urandom);
      rv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom);
      run_op(rd, rv, 1'b0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
